// File: rtl/alu_exec.sv
// ============================================================================
// Module      : alu_exec
// Description : Registered execute stage. It takes an ALU opcode and two
//               operands through a valid/ready handshake and produces a
//               registered result, CR0-style flags and a carry. Multiply is an
//               iterative shift-add, one multiplier bit per cycle.
// Config      : `define ALU_EXEC_MUL_EN compiles in the multiplier. Without it,
//               opcode 1011 is treated as reserved.
// Ports       : clk/rst (async, active-high)
//               in_valid/in_ready, ALU_OP, op_a, op_b     - request side
//               out_valid/out_ready, result, cr_lt/gt/eq,
//               ca, op_err                                 - response side
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_OP,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cr_lt,
  output logic             cr_gt,
  output logic             cr_eq,
  output logic             ca,
  output logic             op_err
);

  localparam logic [3:0] c_OP_AND   = 4'b0000;
  localparam logic [3:0] c_OP_OR    = 4'b0001;
  localparam logic [3:0] c_OP_ADD   = 4'b0010;
  localparam logic [3:0] c_OP_XOR   = 4'b0011;
  localparam logic [3:0] c_OP_NAND  = 4'b0100;
  localparam logic [3:0] c_OP_NOR   = 4'b0101;
  localparam logic [3:0] c_OP_SUB   = 4'b0110;
  localparam logic [3:0] c_OP_EXTSW = 4'b0111;
  localparam logic [3:0] c_OP_SLD   = 4'b1000;
  localparam logic [3:0] c_OP_SRD   = 4'b1001;
  localparam logic [3:0] c_OP_SRAD  = 4'b1010;
  localparam logic [3:0] c_OP_MUL   = 4'b1011;
  localparam logic [3:0] c_OP_CMP   = 4'b1100;
  localparam logic [3:0] c_OP_CMPL  = 4'b1101;
  localparam logic [3:0] c_OP_PASSB = 4'b1110;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_lt, r_gt, r_eq, r_ca, r_err;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_load_single;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_ext;
  logic [SHW-1:0]   w_sh;
  logic             w_sh_big;
  logic [WIDTH-1:0] w_res;
  logic             w_ca, w_err, w_cmp, w_clt, w_cgt, w_ceq;
  logic             w_lt, w_gt, w_eq;

  assign w_accept = in_valid && w_in_ready;

  // Subtract as A + ~B + 1 so the carry out reads directly as "no borrow".
  assign w_sum = {1'b0, op_a} + {1'b0, op_b};
  assign w_dif = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH+1)'(1);

  // The shift amount carries one bit beyond SHW; that bit flags amount >= WIDTH.
  assign w_sh     = op_b[SHW-1:0];
  assign w_sh_big = op_b[SHW];

  generate
    if (WIDTH > 32) begin : g_extsw_wide
      assign w_ext = {{(WIDTH-32){op_a[31]}}, op_a[31:0]};
    end else begin : g_extsw_narrow
      assign w_ext = op_a;
    end
  endgenerate

  always_comb begin
    w_res = '0;
    w_ca  = 1'b0;
    w_err = 1'b0;
    w_cmp = 1'b0;
    w_clt = 1'b0;
    w_cgt = 1'b0;
    w_ceq = 1'b0;
    case (ALU_OP)
      c_OP_AND:   w_res = op_a & op_b;
      c_OP_OR:    w_res = op_a | op_b;
      c_OP_ADD:   begin w_res = w_sum[WIDTH-1:0]; w_ca = w_sum[WIDTH]; end
      c_OP_XOR:   w_res = op_a ^ op_b;
      c_OP_NAND:  w_res = ~(op_a & op_b);
      c_OP_NOR:   w_res = ~(op_a | op_b);
      c_OP_SUB:   begin w_res = w_dif[WIDTH-1:0]; w_ca = w_dif[WIDTH]; end
      c_OP_EXTSW: w_res = w_ext;
      c_OP_SLD:   w_res = w_sh_big ? '0 : (op_a << w_sh);
      c_OP_SRD:   w_res = w_sh_big ? '0 : (op_a >> w_sh);
      c_OP_SRAD:  w_res = w_sh_big ? {WIDTH{op_a[WIDTH-1]}}
                                   : WIDTH'($signed(op_a) >>> w_sh);
      c_OP_CMP: begin
        w_cmp = 1'b1;
        w_ceq = (op_a == op_b);
        w_clt = ($signed(op_a) < $signed(op_b));
        w_cgt = !w_clt && !w_ceq;
      end
      c_OP_CMPL: begin
        w_cmp = 1'b1;
        w_ceq = (op_a == op_b);
        w_clt = (op_a < op_b);
        w_cgt = !w_clt && !w_ceq;
      end
      c_OP_PASSB: w_res = op_b;
      // Reserved 1111, and MUL when the multiplier is not built. With the
      // multiplier built, a MUL never takes the single-cycle load path.
      default:    w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_lt = 1'b0;
    w_gt = 1'b0;
    w_eq = 1'b0;
    if (w_err) begin
      w_lt = 1'b0;
    end else if (w_cmp) begin
      w_lt = w_clt;
      w_gt = w_cgt;
      w_eq = w_ceq;
    end else begin
      w_lt = w_res[WIDTH-1];
      w_eq = (w_res == '0);
      w_gt = !w_lt && !w_eq;
    end
  end

`ifdef ALU_EXEC_MUL_EN
  localparam logic [SHW-1:0] c_CNT_LAST = SHW'(WIDTH-1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
  logic [WIDTH-1:0] w_mul_sum;
  logic             w_is_mul;
  logic             w_mul_done;

  assign w_is_mul      = (ALU_OP == c_OP_MUL);
  assign w_in_ready    = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_load_single = w_accept && !w_is_mul;
  assign w_mul_done    = (r_state == S_MUL) && (r_cnt == c_CNT_LAST);
  // Partial product for the current multiplier LSB; on the last bit this is
  // the final product, loaded straight into the output registers.
  assign w_mul_sum     = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
      S_MUL:   if (r_cnt == c_CNT_LAST)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (w_accept && w_is_mul) begin
      r_cnt    <= '0;
      r_mcand  <= op_a;
      r_mplier <= op_b;
      r_acc    <= '0;
    end else if (r_state == S_MUL) begin
      r_cnt    <= r_cnt + SHW'(1);
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_mul_sum;
    end
  end
`else
  assign w_in_ready    = !r_out_valid || out_ready;
  assign w_load_single = w_accept;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_lt        <= 1'b0;
      r_gt        <= 1'b0;
      r_eq        <= 1'b0;
      r_ca        <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_load_single) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_lt        <= w_lt;
      r_gt        <= w_gt;
      r_eq        <= w_eq;
      r_ca        <= w_ca;
      r_err       <= w_err;
`ifdef ALU_EXEC_MUL_EN
    end else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_mul_sum;
      r_lt        <= w_mul_sum[WIDTH-1];
      r_eq        <= (w_mul_sum == '0);
      r_gt        <= !w_mul_sum[WIDTH-1] && (w_mul_sum != '0);
      r_ca        <= 1'b0;
      r_err       <= 1'b0;
`endif
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign cr_lt     = r_lt;
  assign cr_gt     = r_gt;
  assign cr_eq     = r_eq;
  assign ca        = r_ca;
  assign op_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
// Module      : tb_alu_exec
// Description : Self-checking bench for alu_exec (WIDTH=64). Directed cases
//               plus randomized operations checked against a behavioural
//               model. Honours ALU_EXEC_MUL_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec;

  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ALU_OP;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cr_lt, cr_gt, cr_eq, ca, op_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_mul    = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         lt;
    logic         gt;
    logic         eq;
    logic         ca;
    logic         err;
  } exp_t;

`ifdef ALU_EXEC_MUL_EN
  localparam bit c_MUL_EN = 1'b1;
`else
  localparam bit c_MUL_EN = 1'b0;
`endif

  alu_exec #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALU_OP    (ALU_OP),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cr_lt     (cr_lt),
    .cr_gt     (cr_gt),
    .cr_eq     (cr_eq),
    .ca        (ca),
    .op_err    (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural reference: the architectural meaning of each opcode.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   amt;
    bit   is_cmp;
    logic [W:0] wide;
    e      = '0;
    is_cmp = 1'b0;
    amt    = int'(b[6:0]);
    case (op)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd2:  begin wide = {1'b0, a} + {1'b0, b}; e.res = wide[W-1:0]; e.ca = wide[W]; end
      4'd3:  e.res = a ^ b;
      4'd4:  e.res = ~(a & b);
      4'd5:  e.res = ~(a | b);
      4'd6:  begin e.res = a - b; e.ca = (a >= b); end
      4'd7:  e.res = {{32{a[31]}}, a[31:0]};
      4'd8:  e.res = (amt >= W) ? '0 : a << amt;
      4'd9:  e.res = (amt >= W) ? '0 : a >> amt;
      4'd10: e.res = (amt >= W) ? {W{a[W-1]}} : W'($signed(a) >>> amt);
      4'd11: if (c_MUL_EN) e.res = a * b; else e.err = 1'b1;
      4'd12: begin
        is_cmp = 1'b1;
        e.lt = $signed(a) < $signed(b);
        e.gt = $signed(a) > $signed(b);
        e.eq = (a == b);
      end
      4'd13: begin
        is_cmp = 1'b1;
        e.lt = a < b;
        e.gt = a > b;
        e.eq = (a == b);
      end
      4'd14: e.res = b;
      default: e.err = 1'b1;
    endcase
    if (!is_cmp && !e.err) begin
      e.lt = $signed(e.res) < 0;
      e.eq = (e.res == 0);
      e.gt = $signed(e.res) > 0;
    end
    return e;
  endfunction

  task automatic check_out(input string tag, input exp_t e);
    check({tag, "_valid"}, W'(out_valid), W'(1));
    check({tag, "_res"},   result, e.res);
    check({tag, "_flags"}, W'({cr_lt, cr_gt, cr_eq}), W'({e.lt, e.gt, e.eq}));
    check({tag, "_ca"},    W'(ca), W'(e.ca));
    check({tag, "_err"},   W'(op_err), W'(e.err));
  endtask

  // Present an op and hold in_valid until the accept edge. Returns just after it.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    ALU_OP   = op;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("accept_timeout", W'(0), W'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    ALU_OP   = $urandom_range(0, 15);
    op_a     = {$urandom, $urandom};
    op_b     = {$urandom, $urandom};
  endtask

  // Issue with out_ready low, wait for the result, check latency and value,
  // optionally hold it, then consume it.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    exp_t e;
    int   lat;
    int   exp_lat;
    bit   ready_seen;
    e          = model(op, a, b);
    exp_lat    = (op == 4'd11 && c_MUL_EN) ? W : 0;
    out_ready  = 1'b0;
    issue(op, a, b);
    lat        = 0;
    ready_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, W'(lat), W'(exp_lat));
    if (exp_lat != 0) check({tag, "_busy"}, W'(ready_seen), W'(0));
    check_out(tag, e);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      check({tag, "_hold_res"}, result, e.res);
      check({tag, "_hold_rdy"}, W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_drain"}, W'(out_valid), W'(0));
    out_ready = 1'b0;
  endtask

  initial begin
    exp_t e;
    bit   late_valid;
    logic [3:0]   op;
    logic [W-1:0] a, b;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ALU_OP    = 4'd0;
    op_a      = '0;
    op_b      = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_valid", W'(out_valid), W'(0));
    check("rst_res",   result, W'(0));
    check("rst_flags", W'({cr_lt, cr_gt, cr_eq, ca, op_err}), W'(0));
    check("rst_ready", W'(in_ready), W'(1));

    // Arithmetic boundaries
    run_op("add_wrap", 4'd2, {W{1'b1}}, W'(1), 0);
    run_op("sub_neg",  4'd6, W'(3), W'(5), 0);
    run_op("cmp_s",    4'd12, {W{1'b1}}, W'(1), 0);
    run_op("cmp_u",    4'd13, {W{1'b1}}, W'(1), 0);
    run_op("cmp_eq",   4'd12, W'(42), W'(42), 0);
    run_op("srad_big", 4'd10, 64'h8000_0000_0000_0000, W'(64), 0);
    run_op("sld_big",  4'd8,  64'h8000_0000_0000_0000, W'(64), 0);
    run_op("srd_4",    4'd9,  W'(16), W'(4), 0);
    run_op("extsw",    4'd7,  64'h1234_5678_8000_0001, W'(0), 0);
    run_op("rsvd",     4'd15, W'(7), W'(9), 0);
    run_op("mul",      4'd11, W'(16'h1234), W'(16'h10), 0);

    // Backpressure: pending result holds, then consume + load on one edge
    out_ready = 1'b0;
    issue(4'd3, 64'hF0F0, 64'h0FF0);
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", W'(in_ready), W'(0));
      check("bp_res",   result, W'(64'hFF00));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(4'd2, W'(1), W'(2));
    check("bp_newvalid", W'(out_valid), W'(1));
    check("bp_newres",   result, W'(3));
    @(posedge clk); #1;
    check("bp_drain", W'(out_valid), W'(0));
    out_ready = 1'b0;

    // Reset in the middle of a long operation
    out_ready = 1'b1;
    issue(4'd11, W'(5), W'(7));
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_valid", W'(out_valid), W'(0));
    check("mrst_res",   result, W'(0));
    @(posedge clk); #1 rst = 1'b0;
    check("mrst_ready", W'(in_ready), W'(1));
    late_valid = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) late_valid = 1'b1;
    end
    check("mrst_late", W'(late_valid), W'(0));
    run_op("mrst_add", 4'd2, W'(1), W'(1), 0);

    // Randomized operations
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd11) begin
        if (n_mul >= 4) op = 4'd2;
        else n_mul++;
      end
      case ($urandom_range(0, 3))
        0:       a = W'($urandom_range(0, 20));
        1:       a = {W{1'b1}} - W'($urandom_range(0, 3));
        default: a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 3))
        0:       b = W'($urandom_range(0, 127));
        1:       b = a;
        default: b = {$urandom, $urandom};
      endcase
      run_op("rnd", op, a, b, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
